multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter ALUOP_W, default 3, width of alu_op.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port op  input  6  instruction opcode field, IR[31:26].
REQ-005 SHALL have port funct  input  6  R-type function field, IR[5:0].
REQ-006 SHALL have port zero  input  1  ALU zero flag.
REQ-007 SHALL have ports pc_wr, ir_wr, rf_wr, dm_wr  output  1 each  PC, IR, register-file and data-memory write enables.
REQ-008 SHALL have port mux4_32sel  output  2  writeback data select: 00 ALUout, 01 DMout, 10 PC_add_4, 11 extout.
REQ-009 SHALL have port mux4_5sel  output  2  write register select: 00 rt, 01 rd, 10 $31.
REQ-010 SHALL have ports alu_src  output  1 (0 reg, 1 ext); ext_op  output  2 (00 zero, 01 sign, 10 lui<<16); npc_sel  output  2 (00 PC+4, 01 branch, 10 jump, 11 jr); alu_op  output  ALUOP_W (000 add, 001 sub, 010 or).
REQ-011 SHALL have port retire  output  1  one-cycle pulse on the last cycle of each instruction.

Function
REQ-012 SHALL implement Moore FSM states FETCH, DECODE, EXE, MEM_RD, MEM_WR, WB, BR, JMP; outputs SHALL be decoded from the state register plus op/funct latched at DECODE.
REQ-013 FETCH: ir_wr=1, pc_wr=1, npc_sel=00; next DECODE.
REQ-014 DECODE: latch op/funct; addu/subu/ori/lui/lw/sw -> EXE; beq -> BR; j/jal/jr -> JMP; any other encoding -> FETCH with retire=1 and no write enable asserted.
REQ-015 EXE: alu_op per instruction (lw/sw add, subu sub, ori or), alu_src=1 for ori/lw/sw/lui; lw -> MEM_RD, sw -> MEM_WR, others -> WB.
REQ-016 MEM_RD -> WB; MEM_WR: dm_wr=1, retire=1, next FETCH.
REQ-017 WB: rf_wr=1, retire=1; addu/subu mux4_32sel=00, mux4_5sel=01; ori sel 00/00; lw 01/00; lui 11/00 with ext_op=10; next FETCH.
REQ-018 BR: alu_op=sub; pc_wr=zero, npc_sel=01, retire=1; next FETCH.
REQ-019 JMP: pc_wr=1, retire=1; j npc_sel=10; jal npc_sel=10, rf_wr=1, mux4_32sel=10, mux4_5sel=10; jr npc_sel=11; next FETCH.
REQ-020 Instruction latency in cycles SHALL be: lw 5; R-type/ori/lui/sw 4; beq/j/jal/jr 3; illegal 2.
REQ-021 Outside states named in REQ-013..019 every write enable SHALL be 0; pc_wr and rf_wr SHALL never both assert except in JMP for jal.
REQ-022 Decoding SHALL use only latched op/funct; op/funct changes after DECODE SHALL not alter the sequence.
REQ-023 Unreachable state encodings SHALL return to FETCH next cycle with all enables 0.

Reset
REQ-024 While rst_n=0, state SHALL be FETCH-pending with all enables, retire and selects at 0; first rising edge after deassertion SHALL be a FETCH cycle.
REQ-025 Reset asserted mid-instruction SHALL abort it immediately (asynchronously) with no further write enable pulse.

Configuration
REQ-026 Macro MULTICYCLE_CTRL_JAL_EN defined: jal and jr decoded per REQ-019.
REQ-027 Macro absent: jal and jr SHALL be treated as illegal per REQ-014; j unaffected.

Structure
REQ-028 Opcode/funct constants, state encodings and all select encodings SHALL live in shared package mips_defs_pkg.
REQ-029 Combinational output decode SHALL be sub-module ctrl_out_dec (state, op, funct, zero in; all control outputs out); FSM register stays in multicycle_ctrl.

Verification
REQ-030 Reset then addu (op=000000, funct=100001) -> ir_wr cycle 1, rf_wr=1 with mux4_32sel=00, mux4_5sel=01, retire in cycle 4.
REQ-031 lw (op=100011) -> states FETCH,DECODE,EXE,MEM_RD,WB; WB mux4_32sel=01, mux4_5sel=00; retire cycle 5.
REQ-032 beq (op=000100) with zero=1 -> pc_wr=1, npc_sel=01 cycle 3; repeat with zero=0 -> pc_wr=0, retire still cycle 3.
REQ-033 jal (op=000011), macro defined -> cycle 3 rf_wr=1, mux4_32sel=10, mux4_5sel=10, npc_sel=10; macro absent -> retire cycle 2, no enables.
REQ-034 op=111111 -> retire cycle 2, no write enable; rst_n pulsed low during lw MEM_RD -> rf_wr never asserts, FETCH next.
REQ-035 sw (op=101011) with op forced to 000000 after DECODE -> dm_wr=1 cycle 4, rf_wr stays 0.

Source files
------------

// File: rtl/mips_defs_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, FSM states, selects.
// Defining MULTICYCLE_CTRL_JAL_EN enables decoding of jal and jr; otherwise both are illegal.
package mips_defs_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXE, S_MEM_RD, S_MEM_WR, S_WB, S_BR, S_JMP
  } state_t;

  typedef enum logic [1:0] {WD_ALU = 2'b00, WD_DM = 2'b01, WD_PC4 = 2'b10, WD_EXT = 2'b11} wd_sel_t;
  typedef enum logic [1:0] {WR_RT = 2'b00, WR_RD = 2'b01, WR_RA = 2'b10} wr_sel_t;
  typedef enum logic [1:0] {EXT_ZERO = 2'b00, EXT_SIGN = 2'b01, EXT_LUI = 2'b10} ext_t;
  typedef enum logic [1:0] {NPC_PC4 = 2'b00, NPC_BR = 2'b01, NPC_J = 2'b10, NPC_JR = 2'b11} npc_t;
  typedef enum logic [2:0] {ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_OR = 3'b010} alu_t;

  typedef enum logic [3:0] {
    I_ADDU, I_SUBU, I_ORI, I_LUI, I_LW, I_SW, I_BEQ, I_J, I_JAL, I_JR, I_ILL
  } instr_t;

  typedef struct packed {
    logic    pc_wr;
    logic    ir_wr;
    logic    rf_wr;
    logic    dm_wr;
    wd_sel_t wd_sel;
    wr_sel_t wr_sel;
    logic    alu_src;
    ext_t    ext_op;
    npc_t    npc_sel;
    alu_t    alu_op;
    logic    retire;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = ctrl_t'(0);

  function automatic instr_t classify(input logic [5:0] op, input logic [5:0] funct);
    instr_t c;
    c = I_ILL;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: c = I_ADDU;
          FN_SUBU: c = I_SUBU;
`ifdef MULTICYCLE_CTRL_JAL_EN
          FN_JR:   c = I_JR;
`endif
          default: c = I_ILL;
        endcase
      end
      OP_ORI:  c = I_ORI;
      OP_LUI:  c = I_LUI;
      OP_LW:   c = I_LW;
      OP_SW:   c = I_SW;
      OP_BEQ:  c = I_BEQ;
      OP_J:    c = I_J;
`ifdef MULTICYCLE_CTRL_JAL_EN
      OP_JAL:  c = I_JAL;
`endif
      default: c = I_ILL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ctrl_out_dec.sv
// Combinational control-output decode from FSM state plus the instruction fields.
module ctrl_out_dec
  import mips_defs_pkg::*;
(
  input  state_t      state,
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  input  logic        zero,
  output ctrl_t       ctrl
);

  instr_t instr;

  assign instr = classify(op, funct);

  always_comb begin
    // NOTE: default every field first so no path leaves an output unassigned (no latches).
    ctrl = CTRL_IDLE;
    case (state)
      S_FETCH: begin
        ctrl.ir_wr   = 1'b1;
        ctrl.pc_wr   = 1'b1;
        ctrl.npc_sel = NPC_PC4;
      end
      S_DECODE: ctrl.retire = (instr == I_ILL);
      S_EXE: begin
        case (instr)
          I_SUBU: ctrl.alu_op = ALU_SUB;
          I_ORI: begin
            ctrl.alu_op  = ALU_OR;
            ctrl.alu_src = 1'b1;
            ctrl.ext_op  = EXT_ZERO;
          end
          I_LW, I_SW: begin
            ctrl.alu_src = 1'b1;
            ctrl.ext_op  = EXT_SIGN;
          end
          I_LUI: begin
            ctrl.alu_src = 1'b1;
            ctrl.ext_op  = EXT_LUI;
          end
          default: ;
        endcase
      end
      S_MEM_WR: begin
        ctrl.dm_wr  = 1'b1;
        ctrl.retire = 1'b1;
      end
      S_WB: begin
        ctrl.rf_wr  = 1'b1;
        ctrl.retire = 1'b1;
        case (instr)
          I_ADDU, I_SUBU: ctrl.wr_sel = WR_RD;
          I_LW:           ctrl.wd_sel = WD_DM;
          I_LUI: begin
            ctrl.wd_sel = WD_EXT;
            ctrl.ext_op = EXT_LUI;
          end
          default: ;
        endcase
      end
      S_BR: begin
        ctrl.alu_op  = ALU_SUB;
        ctrl.pc_wr   = zero;
        ctrl.npc_sel = NPC_BR;
        ctrl.retire  = 1'b1;
      end
      S_JMP: begin
        ctrl.pc_wr  = 1'b1;
        ctrl.retire = 1'b1;
        case (instr)
          I_J:  ctrl.npc_sel = NPC_J;
          I_JAL: begin
            ctrl.npc_sel = NPC_J;
            ctrl.rf_wr   = 1'b1;
            ctrl.wd_sel  = WD_PC4;
            ctrl.wr_sel  = WR_RA;
          end
          I_JR: ctrl.npc_sel = NPC_JR;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM: state register and op/funct latch; outputs via ctrl_out_dec.
module multicycle_ctrl
  import mips_defs_pkg::*;
#(
  parameter int ALUOP_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               zero,
  output logic               pc_wr,
  output logic               ir_wr,
  output logic               rf_wr,
  output logic               dm_wr,
  output logic [1:0]         mux4_32sel,
  output logic [1:0]         mux4_5sel,
  output logic               alu_src,
  output logic [1:0]         ext_op,
  output logic [1:0]         npc_sel,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               retire
);

  state_t     state;
  logic [5:0] op_q;
  logic [5:0] funct_q;
  logic [5:0] dec_op;
  logic [5:0] dec_funct;
  instr_t     instr;
  ctrl_t      ctrl;
  ctrl_t      ctrl_g;

  // IR is valid from DECODE on; later states see only the copy latched at DECODE.
  assign dec_op    = (state == S_DECODE) ? op    : op_q;
  assign dec_funct = (state == S_DECODE) ? funct : funct_q;
  assign instr     = classify(dec_op, dec_funct);

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state   <= S_FETCH;
      op_q    <= '0;
      funct_q <= '0;
    end else begin
      case (state)
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          op_q    <= op;
          funct_q <= funct;
          case (instr)
            I_ADDU, I_SUBU, I_ORI, I_LUI, I_LW, I_SW: state <= S_EXE;
            I_BEQ:                                    state <= S_BR;
            I_J, I_JAL, I_JR:                         state <= S_JMP;
            default:                                  state <= S_FETCH;
          endcase
        end
        S_EXE: begin
          case (instr)
            I_LW:    state <= S_MEM_RD;
            I_SW:    state <= S_MEM_WR;
            default: state <= S_WB;
          endcase
        end
        S_MEM_RD: state <= S_WB;
        default:  state <= S_FETCH;
      endcase
    end
  end

  ctrl_out_dec u_dec (
    .state (state),
    .op    (dec_op),
    .funct (dec_funct),
    .zero  (zero),
    .ctrl  (ctrl)
  );

  // Reset forces every output low at once, so a held FETCH state cannot fire ir_wr/pc_wr.
  assign ctrl_g = rst_n ? ctrl : CTRL_IDLE;

  assign pc_wr      = ctrl_g.pc_wr;
  assign ir_wr      = ctrl_g.ir_wr;
  assign rf_wr      = ctrl_g.rf_wr;
  assign dm_wr      = ctrl_g.dm_wr;
  assign mux4_32sel = ctrl_g.wd_sel;
  assign mux4_5sel  = ctrl_g.wr_sel;
  assign alu_src    = ctrl_g.alu_src;
  assign ext_op     = ctrl_g.ext_op;
  assign npc_sel    = ctrl_g.npc_sel;
  assign alu_op     = ALUOP_W'(ctrl_g.alu_op);
  assign retire     = ctrl_g.retire;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle expected control vectors go through a scoreboard queue.
`timescale 1ns/1ps
module tb_multicycle_ctrl;

  typedef struct packed {
    logic       pc_wr;
    logic       ir_wr;
    logic       rf_wr;
    logic       dm_wr;
    logic [1:0] m32;
    logic [1:0] m5;
    logic       alu_src;
    logic [1:0] ext;
    logic [1:0] npc;
    logic [2:0] alu;
    logic       retire;
  } vec_t;

  typedef enum {K_ADDU, K_SUBU, K_ORI, K_LUI, K_LW, K_SW, K_BEQ, K_J, K_JAL, K_JR, K_ILL} kind_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] op = 6'h00;
  logic [5:0] funct = 6'h00;
  logic       zero = 1'b0;
  logic       pc_wr, ir_wr, rf_wr, dm_wr, alu_src, retire;
  logic [1:0] mux4_32sel, mux4_5sel, ext_op, npc_sel;
  logic [2:0] alu_op;

  vec_t sb[$];
  int   tests_run = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.ALUOP_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .pc_wr      (pc_wr),
    .ir_wr      (ir_wr),
    .rf_wr      (rf_wr),
    .dm_wr      (dm_wr),
    .mux4_32sel (mux4_32sel),
    .mux4_5sel  (mux4_5sel),
    .alu_src    (alu_src),
    .ext_op     (ext_op),
    .npc_sel    (npc_sel),
    .alu_op     (alu_op),
    .retire     (retire)
  );

  task automatic check(input string tag, input vec_t e);
    vec_t a;
    a = {pc_wr, ir_wr, rf_wr, dm_wr, mux4_32sel, mux4_5sel, alu_src, ext_op, npc_sel, alu_op, retire};
    tests_run++;
    assert (a === e) else begin
      failed++;
      $error("FAIL %s: observed %b expected %b (pc ir rf dm m32 m5 src ext npc alu ret)", tag, a, e);
    end
  endtask

  // Expected per-cycle vectors for one instruction, written out from the cycle tables.
  function automatic void push_expected(input kind_t k, input logic z);
    vec_t c;
    c = '0; c.pc_wr = 1'b1; c.ir_wr = 1'b1;
    sb.push_back(c);
    c = '0; c.retire = (k == K_ILL);
    sb.push_back(c);
    if (k == K_ILL) return;
    c = '0;
    case (k)
      K_BEQ: begin
        c.alu = 3'b001; c.pc_wr = z; c.npc = 2'b01; c.retire = 1'b1;
        sb.push_back(c);
      end
      K_J, K_JAL, K_JR: begin
        c.pc_wr = 1'b1; c.retire = 1'b1;
        c.npc = (k == K_JR) ? 2'b11 : 2'b10;
        if (k == K_JAL) begin c.rf_wr = 1'b1; c.m32 = 2'b10; c.m5 = 2'b10; end
        sb.push_back(c);
      end
      default: begin
        case (k)
          K_SUBU:     c.alu = 3'b001;
          K_ORI:      begin c.alu = 3'b010; c.alu_src = 1'b1; end
          K_LW, K_SW: begin c.alu_src = 1'b1; c.ext = 2'b01; end
          K_LUI:      begin c.alu_src = 1'b1; c.ext = 2'b10; end
          default: ;
        endcase
        sb.push_back(c);
        if (k == K_LW) sb.push_back('0);
        c = '0; c.retire = 1'b1;
        if (k == K_SW) c.dm_wr = 1'b1;
        else begin
          c.rf_wr = 1'b1;
          case (k)
            K_ADDU, K_SUBU: c.m5 = 2'b01;
            K_LW:           c.m32 = 2'b01;
            K_LUI:          begin c.m32 = 2'b11; c.ext = 2'b10; end
            default: ;
          endcase
        end
        sb.push_back(c);
      end
    endcase
  endfunction

  // Starts just after a rising edge (FETCH cycle) and ends just after the edge closing the instruction.
  task automatic run(input string tag, input kind_t k, input logic [5:0] o, input logic [5:0] f,
                     input logic z, input bit scramble);
    int   cyc;
    vec_t e;
    op = o; funct = f; zero = z;
    push_expected(k, z);
    cyc = 0;
    while (sb.size() > 0) begin
      cyc++;
      @(negedge clk);
      e = sb.pop_front();
      check($sformatf("%s c%0d", tag, cyc), e);
      @(posedge clk); #1;
      if (scramble && cyc == 2) begin op = 6'h00; funct = 6'h21; end
    end
  endtask

  initial begin
    vec_t e;
    #2;
    check("reset_low", '0);
    @(posedge clk); #1;
    check("reset_hold_edge", '0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run("addu",  K_ADDU, 6'h00, 6'h21, 1'b0, 1'b0);
    run("subu",  K_SUBU, 6'h00, 6'h23, 1'b0, 1'b0);
    run("ori",   K_ORI,  6'h0D, 6'h15, 1'b0, 1'b0);
    run("lui",   K_LUI,  6'h0F, 6'h00, 1'b0, 1'b0);
    run("lw",    K_LW,   6'h23, 6'h04, 1'b0, 1'b0);
    run("sw",    K_SW,   6'h2B, 6'h00, 1'b0, 1'b0);
    run("beq_z1", K_BEQ, 6'h04, 6'h00, 1'b1, 1'b0);
    run("beq_z0", K_BEQ, 6'h04, 6'h00, 1'b0, 1'b0);
    run("j",     K_J,    6'h02, 6'h00, 1'b0, 1'b0);
`ifdef MULTICYCLE_CTRL_JAL_EN
    run("jal",   K_JAL,  6'h03, 6'h00, 1'b0, 1'b0);
    run("jr",    K_JR,   6'h00, 6'h08, 1'b0, 1'b0);
`else
    run("jal_off", K_ILL, 6'h03, 6'h00, 1'b0, 1'b0);
    run("jr_off",  K_ILL, 6'h00, 6'h08, 1'b0, 1'b0);
`endif
    run("ill_op3f",  K_ILL, 6'h3F, 6'h00, 1'b0, 1'b0);
    run("ill_funct", K_ILL, 6'h00, 6'h20, 1'b0, 1'b0);
    run("sw_scrambled", K_SW, 6'h2B, 6'h00, 1'b0, 1'b1);

    // lw aborted by a reset pulse inside MEM_RD
    op = 6'h23; funct = 6'h00; zero = 1'b0;
    push_expected(K_LW, 1'b0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      e = sb.pop_front();
      check($sformatf("lw_abort c%0d", c), e);
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check("lw_abort in_reset", '0);
    #1;
    rst_n = 1'b1;
    sb.delete();
    run("after_abort_addu", K_ADDU, 6'h00, 6'h21, 1'b0, 1'b0);
    run("tail_ori", K_ORI, 6'h0D, 6'h00, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
